hd_fifo: RTL

HD_FIFO -- requirements
Module: hd_fifo

---
 rtl/hd_pkg.sv | 16 +
 rtl/hd_fifo_mem.sv | 26 ++
 rtl/hd_fifo.sv | 79 +++++++
 3 files changed

// File: rtl/hd_pkg.sv
// Shared constants and width helpers for the hd block family.
package hd_pkg;

  localparam int HD_DATA_WIDTH = 16;
  localparam int HD_DEPTH      = 4;

  // Occupancy must be able to represent the value DEPTH itself, hence depth+1.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hd_fifo_mem.sv
// FIFO storage: one write port, one asynchronous read port, contents never reset.
module hd_fifo_mem
  import hd_pkg::*;
#(
  parameter int DATA_WIDTH = HD_DATA_WIDTH,
  parameter int DEPTH      = HD_DEPTH
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [ptr_width(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [ptr_width(DEPTH)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/hd_fifo.sv
// Valid/ready FIFO with registered flags; control lives here, storage in hd_fifo_mem.
module hd_fifo
  import hd_pkg::*;
#(
  parameter int DATA_WIDTH   = HD_DATA_WIDTH,
  parameter int DEPTH        = HD_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [occ_width(DEPTH)-1:0]  count,
  output logic                         almost_full
);

  localparam int CW = occ_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0]         head_reg, head_next;
  logic [PW-1:0]         tail_reg, tail_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Flags look only at count_reg, so no input reaches s_ready or m_valid combinationally.
  assign s_ready     = (count_reg < CW'(DEPTH));
  assign m_valid     = (count_reg != '0);
  assign almost_full = (count_reg >= CW'(AFULL_THRESH));
  assign count       = count_reg;
  assign m_data      = m_valid ? rd_data : '0;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  // DEPTH is a power of two, so pointer wrap is plain modular overflow.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (push) tail_next = tail_reg + PW'(1);
    if (pop)  head_next = head_reg + PW'(1);
    unique case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // A write during reset lands in storage but is unreachable: tail and count are cleared.
  hd_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (tail_reg),
    .wr_data (s_data),
    .rd_addr (head_reg),
    .rd_data (rd_data)
  );

endmodule
